// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the scanner FSM state encoding and the key-code width helper.
package keypad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DEB,
    S_PUSH,
    S_REL
  } state_t;

  function automatic int code_w(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// Small key-code queue with wrap-bit pointers.
// Head is presented directly from storage; no write-to-read bypass.
module keypad_code_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             empty;
  logic             wr;
  logic             rd;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign valid = !empty;
  // a pop frees the slot in the same cycle, so a full queue still takes it
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Scans a ROWS x COLS key matrix, debounces one key at a time
// and queues its code for a valid/ready consumer.
module matrix_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int  ROWS       = 4,
  parameter int  COLS       = 4,
  parameter int  DWELL      = 4,
  parameter int  DEBOUNCE   = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int CODE_W     = code_w(ROWS, COLS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              overflow
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(DWELL);

  if (DWELL < 3 || ROWS < 2 || ROWS > 8 ||
      COLS < 2 || COLS > 8 ||
      DEBOUNCE < 1 || DEBOUNCE > 255 ||
      FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_param_check
    $error("matrix_keypad_scanner: illegal parameter");
  end

  state_t            state;
  state_t            state_nx;
  logic [ROWS-1:0]   row_m;
  logic [ROWS-1:0]   row_s;
  logic [DW-1:0]     dwell;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row_lat;
  logic [7:0]        cnt;
  logic              idle_seen;
  logic              any_row;
  logic              dwell_end;
  logic              last_col;
  logic              hit;
  logic              cnt_end;
  logic              push;
  logic              pop;
  logic              full;
  logic [CODE_W-1:0] code;

  function automatic logic [RW-1:0] low_row(
    input logic [ROWS-1:0] v
  );
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (v[i]) low_row = RW'(i);
  endfunction

  assign any_row   = |row_s;
  assign dwell_end = (dwell == DW'(DWELL - 1));
  assign last_col  = (col == CW'(COLS - 1));
  assign hit       = row_s[row_lat];
  assign cnt_end   = (cnt == 8'(DEBOUNCE - 1));
  assign code      = CODE_W'(row_lat) * CODE_W'(COLS)
                   + CODE_W'(col);
  assign pop       = key_valid && key_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_m <= '0;
      row_s <= '0;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (any_row && idle_seen) state_nx = S_SCAN;
      S_SCAN:
        if (dwell_end) begin
          if (any_row)       state_nx = S_DEB;
          else if (last_col) state_nx = S_IDLE;
        end
      S_DEB:
        if (!hit)         state_nx = S_IDLE;
        else if (cnt_end) state_nx = S_PUSH;
      S_PUSH:
        state_nx = S_REL;
      S_REL:
        if (!any_row && cnt_end) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    col_out  = '1;
    key_held = 1'b0;
    push     = 1'b0;
    overflow = 1'b0;
    unique case (state)
      S_SCAN: col_out = COLS'(1) << col;
      S_DEB: begin
        col_out  = COLS'(1) << col;
        key_held = 1'b1;
      end
      S_PUSH: begin
        key_held = 1'b1;
        push     = 1'b1;
        overflow = full && !pop;
      end
      S_REL: key_held = 1'b1;
      default: ;
    endcase
  end

  // cnt serves both the press debounce and the release debounce
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_seen <= 1'b0;
      dwell     <= '0;
      col       <= '0;
      row_lat   <= '0;
      cnt       <= '0;
    end else begin
      idle_seen <= (state == S_IDLE) && any_row;
      dwell <= (state == S_SCAN && !dwell_end)
             ? dwell + 1'b1 : '0;
      if (state == S_IDLE)
        col <= '0;
      else if (state == S_SCAN && dwell_end &&
               !any_row && !last_col)
        col <= col + 1'b1;
      if (state == S_SCAN && dwell_end && any_row)
        row_lat <= low_row(row_s);
      unique case (state)
        S_DEB:   cnt <= hit ? cnt + 1'b1 : '0;
        S_REL:   cnt <= any_row ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  keypad_code_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .din     (code),
    .pop     (pop),
    .dout    (key_code),
    .valid   (key_valid),
    .full    (full)
  );

endmodule
